// File: rtl/reaction_timer_if.sv
// Interface between the reaction timer and the LED-delay / display logic.
//   master : drives arm, led_on, button; observes the result outputs
//   slave  : the reaction timer itself
//   arm          - single-cycle round start pulse
//   led_on       - LED lit level from the delay stage
//   button       - raw asynchronous player button
//   reaction_ms  - last measured reaction time (ms)
//   best_ms      - smallest valid reaction time since reset
//   result_valid - reaction_ms holds a completed round
//   false_start  - button pressed before the LED lit
//   timeout      - no press within the limit
//   busy         - round in progress
interface reaction_timer_if #(
  parameter int unsigned CNT_W = 14
);
  logic             arm;
  logic             led_on;
  logic             button;
  logic [CNT_W-1:0] reaction_ms;
  logic [CNT_W-1:0] best_ms;
  logic             result_valid;
  logic             false_start;
  logic             timeout;
  logic             busy;

  modport master (
    output arm, led_on, button,
    input  reaction_ms, best_ms, result_valid, false_start, timeout, busy
  );

  modport slave (
    input  arm, led_on, button,
    output reaction_ms, best_ms, result_valid, false_start, timeout, busy
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time measurement stage of the reaction game.
// Once armed, waits for led_on, then counts milliseconds until the player's
// button press. Reports the result, flags early presses and timeouts, and
// tracks the best time since reset.
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - reaction_timer_if slave modport (round control in, results out)
module reaction_timer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_W    = 14,
  parameter int unsigned MAX_MS   = 9999
) (
  input  logic               clk,
  input  logic               rst,
  reaction_timer_if.slave    bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] PRE_MAX    = CNT_W'(MAX_MS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FAULT
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] reaction_q;
  logic [CNT_W-1:0] best_q;
  logic             valid_q;
  logic             false_start_q;
  logic             timeout_q;
  logic             busy_q;
  logic             btn_meta_q;
  logic             btn_sync_q;
  logic             btn_prev_q;
  logic             press;

  // Rising edge of the synchronized button; a held button yields one press.
  assign press = btn_sync_q & ~btn_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      cnt_q         <= '0;
      reaction_q    <= '0;
      best_q        <= MAX_CNT;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      btn_prev_q    <= 1'b0;
    end else begin
      btn_meta_q <= bus.button;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;

      case (state_q)
        IDLE, DONE, FAULT: begin
          if (bus.arm) begin
            state_q       <= ARMED;
            valid_q       <= 1'b0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        ARMED: begin
          if (press && !bus.led_on) begin
            state_q       <= FAULT;
            false_start_q <= 1'b1;
            busy_q        <= 1'b0;
          end else if (bus.led_on) begin
            // A press coinciding with the LED is swallowed here.
            state_q <= TIMING;
            presc_q <= '0;
            cnt_q   <= '0;
          end
        end
        TIMING: begin
          if (press) begin
            // Press wins over a tick due this cycle, so the reported value
            // is the pre-increment count (at most MAX_MS-1).
            state_q    <= DONE;
            reaction_q <= cnt_q;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
            if (cnt_q < best_q) begin
              best_q <= cnt_q;
            end
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            if (cnt_q == PRE_MAX) begin
              state_q    <= DONE;
              cnt_q      <= MAX_CNT;
              reaction_q <= MAX_CNT;
              timeout_q  <= 1'b1;
              valid_q    <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reaction_ms  = reaction_q;
  assign bus.best_ms      = best_q;
  assign bus.result_valid = valid_q;
  assign bus.false_start  = false_start_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = 14;
  localparam int unsigned MAX_MS   = 20;

  typedef struct {
    string            tag;
    logic [CNT_W-1:0] reaction;
    logic [CNT_W-1:0] best;
    logic             valid;
    logic             fs;
    logic             to;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned model_best = MAX_MS;
  int unsigned model_last = 0;
  exp_t sb[$];

  reaction_timer_if #(.CNT_W(CNT_W)) bus ();

  reaction_timer #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W),
    .MAX_MS  (MAX_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string name, input int unsigned obs, input int unsigned exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
  endtask

  task automatic push(input string tag, input int unsigned r, input int unsigned b,
                      input logic v, input logic f, input logic t, input logic bz);
    exp_t e;
    e.tag = tag; e.reaction = CNT_W'(r); e.best = CNT_W'(b);
    e.valid = v; e.fs = f; e.to = t; e.busy = bz;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("sb_empty", 0, 1 + n_total);
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, "_reaction"}, bus.reaction_ms, e.reaction);
    cmp({e.tag, "_best"}, bus.best_ms, e.best);
    cmp({e.tag, "_valid"}, bus.result_valid, e.valid);
    cmp({e.tag, "_false_start"}, bus.false_start, e.fs);
    cmp({e.tag, "_timeout"}, bus.timeout, e.to);
    cmp({e.tag, "_busy"}, bus.busy, e.busy);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && bus.busy; i++) step(1);
    cmp({tag, "_done_in_budget"}, bus.busy, 0);
  endtask

  task automatic arm_pulse();
    bus.arm = 1'b1;
    step(1);
    bus.arm = 1'b0;
  endtask

  // gap = cycles between raising led_on and raising button. The press reaches
  // the FSM gap+2 TIMING edges later; after k TIMING edges count = k/TICK_DIV.
  task automatic press_round(input string tag, input int unsigned gap,
                             input int unsigned drop_at);
    int unsigned ms;
    bus.led_on = 1'b0;
    arm_pulse();
    step(9);
    bus.led_on = 1'b1;
    if (drop_at != 0 && drop_at < gap) begin
      step(drop_at);
      bus.led_on = 1'b0;
      step(gap - drop_at);
    end else begin
      step(gap);
    end
    bus.button = 1'b1;
    if (gap + 2 > TICK_DIV * MAX_MS) begin
      model_last = MAX_MS;
      push(tag, MAX_MS, model_best, 1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      ms = (gap + 1) / TICK_DIV;
      model_last = ms;
      if (ms < model_best) model_best = ms;
      push(tag, ms, model_best, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    wait_idle(tag, 200);
    check_sb();
    bus.button = 1'b0;
    step(4);
  endtask

  initial begin
    bus.arm = 1'b0;
    bus.led_on = 1'b0;
    bus.button = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    push("reset", 0, MAX_MS, 1'b0, 1'b0, 1'b0, 1'b0);
    check_sb();

    // Normal rounds: 5 ms, then 7 ms with led_on dropping mid-measurement.
    press_round("round5", 20, 0);
    press_round("round7", 28, 10);

    // False start, then LED lighting afterwards must not disturb the result.
    bus.led_on = 1'b0;
    arm_pulse();
    step(3);
    bus.button = 1'b1;
    step(1);
    bus.button = 1'b0;
    push("false_start", model_last, model_best, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle("false_start", 20);
    check_sb();
    bus.led_on = 1'b1;
    step(6);
    push("fs_hold", model_last, model_best, 1'b0, 1'b1, 1'b0, 1'b0);
    check_sb();

    // Re-arm clears the flag; then no press at all -> timeout.
    bus.led_on = 1'b0;
    arm_pulse();
    push("rearm", model_last, model_best, 1'b0, 1'b0, 1'b0, 1'b1);
    check_sb();
    step(3);
    bus.led_on = 1'b1;
    model_last = MAX_MS;
    push("timeout", MAX_MS, model_best, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle("timeout", 120);
    check_sb();

    // Button held across arm and LED: no edge, so no false start.
    bus.led_on = 1'b0;
    bus.button = 1'b1;
    step(5);
    arm_pulse();
    step(3);
    bus.led_on = 1'b1;
    step(2);
    bus.button = 1'b0;
    step(10);
    bus.button = 1'b1;
    model_last = 3;
    if (model_last < model_best) model_best = model_last;
    push("held", 3, model_best, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle("held", 100);
    check_sb();
    bus.button = 1'b0;
    step(4);

    // Reset while TIMING at count 4 aborts the round.
    bus.led_on = 1'b0;
    arm_pulse();
    step(2);
    bus.led_on = 1'b1;
    step(17);
    push("mid_round", model_last, model_best, 1'b0, 1'b0, 1'b0, 1'b1);
    check_sb();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_best = MAX_MS;
    model_last = 0;
    push("mid_reset", 0, MAX_MS, 1'b0, 1'b0, 1'b0, 1'b0);
    check_sb();
    step(3);
    push("mid_reset_hold", 0, MAX_MS, 1'b0, 1'b0, 1'b0, 1'b0);
    check_sb();

    // Press in the same cycle the count would reach MAX_MS -> MAX_MS-1.
    press_round("edge_max", TICK_DIV * MAX_MS - 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Stage directly downstream of the LED-delay stage in the reaction-time game.
- After a round is armed, waits for the "LED lit" level from the delay stage, then counts elapsed milliseconds until the player's button press.
- Reports the result, flags early presses (before the LED) and no-response timeouts, and keeps the best time since reset.
- Outputs feed the display/score logic.

Parameters:
- TICK_DIV, 50000, clk cycles per millisecond tick (50 MHz clock); legal range >= 2.
- CNT_W, 14, width of the millisecond counters.
- MAX_MS, 9999, timeout limit in ms; must fit in CNT_W bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  single-cycle pulse; starts a new round.
- led_on  input  1  level from the delay stage; 1 = LED lit.
- button  input  1  raw, asynchronous player button; 1 = pressed.
- reaction_ms  output  CNT_W  last measured reaction time in ms.
- best_ms  output  CNT_W  smallest valid reaction_ms since reset.
- result_valid  output  1  level; 1 = reaction_ms holds a completed round.
- false_start  output  1  level; button pressed before LED lit.
- timeout  output  1  level; no press within MAX_MS.
- busy  output  1  1 while in ARMED or TIMING.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - reaction_ms=0, best_ms=MAX_MS.
  - result_valid=0, false_start=0, timeout=0, busy=0.
  - Synchronizer flops and prescaler cleared.
  - Reset mid-round aborts the round; no result is reported.
- Button path:
  - Two-flop synchronizer, then rising-edge detect: press = sync_q & ~sync_q_d.
  - press asserts for 1 cycle, 3 cycles after button rises.
  - A held button generates no further presses.
  - led_on is already synchronous and is used directly.
- State IDLE:
  - busy=0.
  - arm -> ARMED: clears result_valid, false_start and timeout; reaction_ms keeps its value.
- State ARMED:
  - busy=1.
  - press while led_on=0 -> FAULT, false_start=1.
  - led_on=1 (and no press) -> TIMING; prescaler=0, ms count=0.
  - press and led_on=1 in the same cycle -> TIMING; that press is consumed and is not a false start.
- State TIMING:
  - busy=1.
  - Prescaler counts 0..TICK_DIV-1 and wraps. On each wrap, ms count increments by 1.
  - press -> DONE: reaction_ms=count (the current count, excluding any increment due that cycle), result_valid=1.
    - If count < best_ms, then best_ms=count; equal values do not update.
  - count reaches MAX_MS with no press -> DONE: reaction_ms=MAX_MS, timeout=1, result_valid=1; best_ms is not updated.
  - press in the same cycle count becomes MAX_MS -> treated as a press with reaction_ms=MAX_MS-1; best update rule applies.
  - led_on falling during TIMING is ignored; timing continues.
  - The counter never exceeds MAX_MS.
- States DONE and FAULT:
  - busy=0; all outputs held.
  - Further presses and led_on changes are ignored.
  - arm -> ARMED, with flag clearing as in IDLE.
- arm while ARMED or TIMING is ignored.
- result_valid, false_start and timeout are mutually exclusive, except that timeout implies result_valid.
- Arithmetic:
  - Unsigned.
  - Prescaler width = clog2(TICK_DIV).
  - Comparisons are CNT_W bits wide, with no overflow possible.

Test Plan (run with TICK_DIV=4, MAX_MS=20):
- Reset values: hold rst 2 cycles -> reaction_ms=0, best_ms=20, all flags 0, busy=0.
- Normal round:
  - arm pulse; led_on=1 at cycle 10; button rises 5 ticks plus 1 cycle later (after sync latency).
  - Expect result_valid=1, reaction_ms=5, best_ms=5, busy=0.
  - Second round measuring 7 -> reaction_ms=7, best_ms stays 5.
- False start:
  - arm; button pulse while led_on=0.
  - Expect false_start=1, result_valid=0, best_ms unchanged.
  - Then led_on=1 -> no change; next arm clears false_start.
- Timeout:
  - arm; led_on=1; no button for 80+ cycles.
  - Expect timeout=1, result_valid=1, reaction_ms=20, best_ms unchanged.
- Held button / edge detect:
  - Button held high from before arm through led_on rising -> no false_start, since no new edge.
  - Release and re-press at 3 ms -> reaction_ms=3.
- Reset mid-round: rst asserted during TIMING at count 4 -> IDLE, all outputs at reset values, best_ms=20.
